// File: rtl/sample_pkg.sv
// Shared defaults and FSM state encoding for the sample recorder slice.
package sample_pkg;
    localparam int DW_DEF    = 20;
    localparam int DEPTH_DEF = 150;
    localparam int AW_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;
endpackage

// File: rtl/sample_recorder_if.sv
// Capture/readback bus of the sample recorder; master drives samples and reads.
interface sample_recorder_if import sample_pkg::*; #(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_x;
    logic [DW-1:0] in_y;
    logic          in_last;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          overflow;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_x;
    logic [DW-1:0] rd_y;

    modport master (
        output start, in_valid, in_x, in_y, in_last, rd_en, rd_addr,
        input  in_ready, busy, done, count, overflow, rd_x, rd_y
    );

    modport slave (
        input  start, in_valid, in_x, in_y, in_last, rd_en, rd_addr,
        output in_ready, busy, done, count, overflow, rd_x, rd_y
    );
endinterface

// File: rtl/sample_ram.sv
// Single write port, registered read port; a same-edge read returns the old word.
module sample_ram #(
    parameter int W  = 40,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    // Sized to the full address space so any rd_addr is a legal index.
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/sample_recorder.sv
// Frame capture FSM: stores (x,y) pairs until in_last or DEPTH, then pulses done.
module sample_recorder import sample_pkg::*; #(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input logic              clk,
    input logic              rst,
    sample_recorder_if.slave bus
);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t          state;
    logic [AW:0]     cnt;
    logic [AW:0]     cnt_inc;
    logic            ovf;
    logic            done_q;
    logic            accept;
    logic [2*DW-1:0] rdata;

    assign accept  = bus.in_valid && (state == CAPTURE);
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            ovf    <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= CAPTURE;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        cnt <= cnt_inc;
                        // A full frame that also carries in_last is a clean end.
                        if (bus.in_last || cnt_inc == DEPTH_C) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                            ovf    <= !bus.in_last;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sample_ram #(.W(2*DW), .AW(AW)) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (accept && rst),
        .waddr (cnt[AW-1:0]),
        .wdata ({bus.in_x, bus.in_y}),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (rdata)
    );

    assign bus.in_ready = (state == CAPTURE);
    assign bus.busy     = (state == CAPTURE);
    assign bus.done     = done_q;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;
    assign bus.rd_x     = rdata[2*DW-1:DW];
    assign bus.rd_y     = rdata[DW-1:0];
endmodule

// File: tb/tb_sample_recorder.sv
// Randomised bench for sample_recorder against a frame-level reference model.
module tb_sample_recorder;
    localparam int DW = 20, DEPTH = 150, AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sample_recorder_if #(.DW(DW), .AW(AW)) bus ();
    sample_recorder #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0, n_fail = 0, n_done = 0;

    // reference: capture flag, done-cycle flag, count, overflow, memory image
    bit            m_cap, m_dn, m_ovf, m_rk;
    int            m_cnt;
    logic [DW-1:0] mx [256];
    logic [DW-1:0] my [256];
    bit            mk [256];
    logic [DW-1:0] m_rx, m_ry;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!rst) begin
            m_cap = 0; m_dn = 0; m_cnt = 0; m_ovf = 0;
            m_rx = '0; m_ry = '0; m_rk = 1;
        end else begin
            if (bus.rd_en) begin
                m_rk = mk[bus.rd_addr];
                m_rx = mx[bus.rd_addr];
                m_ry = my[bus.rd_addr];
            end
            if (m_dn) m_dn = 0;
            else if (m_cap) begin
                if (bus.in_valid) begin
                    mx[m_cnt] = bus.in_x; my[m_cnt] = bus.in_y; mk[m_cnt] = 1;
                    m_cnt++;
                    if (bus.in_last) begin
                        m_cap = 0; m_dn = 1;
                    end else if (m_cnt == DEPTH) begin
                        m_cap = 0; m_dn = 1; m_ovf = 1;
                    end
                end
            end else if (bus.start) begin
                m_cap = 1; m_cnt = 0; m_ovf = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (bus.done) n_done++;
        chk("in_ready", bus.in_ready, m_cap);
        chk("busy", bus.busy, m_cap);
        chk("done", bus.done, m_dn);
        chk("count", bus.count, m_cnt);
        chk("overflow", bus.overflow, m_ovf);
        if (m_rk) begin
            chk("rd_x", bus.rd_x, m_rx);
            chk("rd_y", bus.rd_y, m_ry);
        end
    endtask

    task automatic drv(input bit s, input bit v, input bit l, input bit re, input int ra,
                       input logic [DW-1:0] x, input logic [DW-1:0] y);
        bus.start = s; bus.in_valid = v; bus.in_last = l;
        bus.rd_en = re; bus.rd_addr = AW'(ra);
        bus.in_x = x; bus.in_y = y;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, '0, '0);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'($urandom);
    endfunction

    initial begin
        logic [DW-1:0] ox, oy, nx, ny;
        int nv;
        for (int i = 0; i < 256; i++) mk[i] = 0;
        m_rk = 0;
        idle();
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.in_ready, 0);

        // basic 5-sample frame and readback
        n_done = 0;
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 1; i <= 5; i++) begin
            drv(0, 1, i == 5, 0, 0, DW'(i), DW'(10 * i)); step();
        end
        idle(); step();
        chk("f1_done_pulses", n_done, 1);
        chk("f1_count", bus.count, 5);
        chk("f1_ovf", bus.overflow, 0);
        for (int a = 0; a < 5; a++) begin
            drv(0, 0, 0, 1, a, '0, '0); step();
            chk("f1_rd_x", bus.rd_x, a + 1);
            chk("f1_rd_y", bus.rd_y, 10 * (a + 1));
        end
        idle(); step(); step();
        chk("f1_rd_hold", bus.rd_x, 5);

        // in_valid toggling
        nv = 0;
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 0; i < 11; i++) begin
            drv(0, i % 2 == 0, i == 10, 0, 0, rnd(), rnd());
            if (i % 2 == 0) nv++;
            step();
        end
        idle(); step();
        chk("tog_count", bus.count, nv);

        // overflow at DEPTH
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 0; i < DEPTH; i++) begin
            drv(0, 1, 0, 0, 0, rnd(), rnd()); step();
        end
        chk("ovf_done", bus.done, 1);
        chk("ovf_flag", bus.overflow, 1);
        chk("ovf_count", bus.count, DEPTH);
        chk("ovf_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 0, 0, rnd(), rnd()); step();
        end
        chk("ovf_151_ignored", bus.count, DEPTH);
        idle(); step();

        // reset mid-frame aborts
        n_done = 0;
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 0; i < 3; i++) begin
            drv(0, 1, 0, 0, 0, rnd(), rnd()); step();
        end
        drv(0, 1, 0, 0, 0, rnd(), rnd());
        rst = 1'b0; step();
        rst = 1'b1; idle(); step(); step();
        chk("abort_count", bus.count, 0);
        chk("abort_ready", bus.in_ready, 0);
        chk("abort_no_done", n_done, 0);

        // start ignored in CAPTURE and DONE
        n_done = 0;
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 0; i < 4; i++) begin
            drv(i % 2 == 0 || i == 3, 1, i == 3, 0, 0, rnd(), rnd()); step();
        end
        drv(1, 0, 0, 0, 0, '0, '0); step();
        idle(); step();
        chk("start_ign_count", bus.count, 4);
        chk("start_ign_busy", bus.busy, 0);
        chk("start_ign_pulses", n_done, 1);

        // read-before-write at addr 2
        ox = mx[2]; oy = my[2];
        drv(1, 0, 0, 0, 0, '0, '0); step();
        for (int i = 0; i < 2; i++) begin
            drv(0, 1, 0, 0, 0, rnd(), rnd()); step();
        end
        nx = rnd(); ny = rnd();
        drv(0, 1, 0, 1, 2, nx, ny); step();
        chk("rbw_old_x", bus.rd_x, ox);
        chk("rbw_old_y", bus.rd_y, oy);
        drv(0, 0, 0, 1, 2, '0, '0); step();
        chk("rbw_new_x", bus.rd_x, nx);
        chk("rbw_new_y", bus.rd_y, ny);
        drv(0, 1, 1, 0, 0, rnd(), rnd()); step();
        idle(); step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom % 60) != 0;
            drv(($urandom % 6) == 0, $urandom % 2, ($urandom % 12) == 0, $urandom % 2,
                $urandom % DEPTH, rnd(), rnd());
            step();
        end
        rst = 1'b1; idle(); step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
